// File: rtl/adder_sum_accumulator.sv
// Accumulates COUNT {carryout, sum} adder results into a wide block total and
// presents it with a sticky overflow flag on a valid/ready output handshake.
//
// state | meaning
// IDLE  | no samples in the current block, acc = 0, count = 0
// ACCUM | 0 < count < COUNT samples accepted, waiting for more
// HOLD  | block complete, total/overflow presented, inputs blocked
module adder_sum_accumulator #(
    parameter int ACC_WIDTH = 16,
    parameter int COUNT     = 4,
    localparam int CNT_WIDTH = $clog2(COUNT + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           sum,
    input  logic                 carryout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] total,
    output logic                 overflow
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(COUNT - 1);

    logic [1:0]           state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] count;
    logic [ACC_WIDTH:0]   acc_next;
    logic                 accept;
    logic                 last_sample;

    assign in_ready    = (state != HOLD);
    assign out_valid   = (state == HOLD);
    assign accept      = in_valid && in_ready;
    assign last_sample = (count == LAST);

    // acc is held at 0 in IDLE, so one adder serves both the first and later samples
    assign acc_next = {1'b0, acc} + {{(ACC_WIDTH - 8){1'b0}}, carryout, sum};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            count    <= '0;
            total    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc      <= acc_next[ACC_WIDTH-1:0];
                        overflow <= overflow | acc_next[ACC_WIDTH];
                        if (last_sample) begin
                            total <= acc_next[ACC_WIDTH-1:0];
                            count <= '0;
                            state <= HOLD;
                        end else begin
                            count <= count + CNT_WIDTH'(1);
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    // total is left alone so it keeps the last result after release
                    if (out_ready) begin
                        acc      <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    acc      <= '0;
                    count    <= '0;
                    overflow <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench for adder_sum_accumulator: default, narrow (ACC_WIDTH=10) and
// single-sample (COUNT=1) instances share stimulus; expectations are hand-computed.
module tb_adder_sum_accumulator;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  sum = 8'h00;
    logic        carryout = 1'b0;
    logic        out_ready = 1'b0;

    logic        rdy0, ov0, of0;
    logic [15:0] tot0;
    logic        rdy1, ov1, of1;
    logic [9:0]  tot1;
    logic        rdy2, ov2, of2;
    logic [15:0] tot2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    adder_sum_accumulator dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
        .sum(sum), .carryout(carryout), .out_valid(ov0), .out_ready(out_ready),
        .total(tot0), .overflow(of0)
    );

    adder_sum_accumulator #(.ACC_WIDTH(10), .COUNT(4)) dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
        .sum(sum), .carryout(carryout), .out_valid(ov1), .out_ready(out_ready),
        .total(tot1), .overflow(of1)
    );

    adder_sum_accumulator #(.ACC_WIDTH(16), .COUNT(1)) dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy2),
        .sum(sum), .carryout(carryout), .out_valid(ov2), .out_ready(out_ready),
        .total(tot2), .overflow(of2)
    );

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drive_block(input logic [8:0] v);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            {carryout, sum} = v;
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", ov0); end
        n_cmp++; if (tot0 !== 16'h0000) begin n_bad++; $display("FAIL reset_total got %h want 0000", tot0); end
        n_cmp++; if (of0 !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", of0); end
        n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", rdy0); end
    endtask

    task automatic test_full_scale();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL full_early_valid step %0d got %b want 0", i, ov0); end
            in_valid = 1'b1;
            {carryout, sum} = 9'h1FF;
        end
        @(negedge clock);
        in_valid = 1'b0;
        n_cmp++; if (ov0 !== 1'b1) begin n_bad++; $display("FAIL full_out_valid got %b want 1", ov0); end
        n_cmp++; if (tot0 !== 16'h07FC) begin n_bad++; $display("FAIL full_total got %h want 07fc", tot0); end
        n_cmp++; if (of0 !== 1'b0) begin n_bad++; $display("FAIL full_overflow got %b want 0", of0); end
        n_cmp++; if (tot1 !== 10'h3FC) begin n_bad++; $display("FAIL wrap_total got %h want 3fc", tot1); end
        n_cmp++; if (of1 !== 1'b1) begin n_bad++; $display("FAIL wrap_overflow got %b want 1", of1); end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL full_release got %b want 0", ov0); end
        n_cmp++; if (of1 !== 1'b0) begin n_bad++; $display("FAIL wrap_overflow_clear got %b want 0", of1); end
        drive_block(9'h001);
        n_cmp++; if (ov1 !== 1'b1) begin n_bad++; $display("FAIL wrap2_out_valid got %b want 1", ov1); end
        n_cmp++; if (tot1 !== 10'h004) begin n_bad++; $display("FAIL wrap2_total got %h want 004", tot1); end
        n_cmp++; if (of1 !== 1'b0) begin n_bad++; $display("FAIL wrap2_overflow got %b want 0", of1); end
    endtask

    task automatic test_gapped();
        logic [8:0] vals [4] = '{9'h010, 9'h020, 9'h030, 9'h040};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            {carryout, sum} = vals[i];
            @(negedge clock);
            in_valid = 1'b0;
            if (i < 3) begin
                n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL gap_early_valid step %0d got %b want 0", i, ov0); end
                repeat (2) @(negedge clock);
                n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL gap_idle_valid step %0d got %b want 0", i, ov0); end
            end
        end
        n_cmp++; if (ov0 !== 1'b1) begin n_bad++; $display("FAIL gap_out_valid got %b want 1", ov0); end
        n_cmp++; if (tot0 !== 16'h00A0) begin n_bad++; $display("FAIL gap_total got %h want 00a0", tot0); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            {carryout, sum} = 9'h019;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            {carryout, sum} = 9'h055;
            n_cmp++; if (ov0 !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid cyc %0d got %b want 1", i, ov0); end
            n_cmp++; if (tot0 !== 16'h0064) begin n_bad++; $display("FAIL bp_total cyc %0d got %h want 0064", i, tot0); end
            n_cmp++; if (rdy0 !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, rdy0); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL bp_release got %b want 0", ov0); end
        n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after got %b want 1", rdy0); end
        drive_block(9'h001);
        n_cmp++; if (tot0 !== 16'h0004) begin n_bad++; $display("FAIL bp_next_total got %h want 0004", tot0); end
        n_cmp++; if (of0 !== 1'b0) begin n_bad++; $display("FAIL bp_next_overflow got %b want 0", of0); end
    endtask

    task automatic test_reset_mid_block();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            {carryout, sum} = 9'h0FF;
        end
        @(negedge clock);
        in_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got %b want 0", ov0); end
        n_cmp++; if (tot0 !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_total got %h want 0000", tot0); end
        n_cmp++; if (of0 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_overflow got %b want 0", of0); end
        #4 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL mid_spurious step %0d got %b want 0", i, ov0); end
            in_valid = 1'b1;
            {carryout, sum} = 9'h001;
        end
        @(negedge clock);
        in_valid = 1'b0;
        n_cmp++; if (ov0 !== 1'b1) begin n_bad++; $display("FAIL mid_out_valid got %b want 1", ov0); end
        n_cmp++; if (tot0 !== 16'h0004) begin n_bad++; $display("FAIL mid_total got %h want 0004", tot0); end
    endtask

    task automatic test_count_one();
        logic [8:0] vals [4] = '{9'h1FF, 9'h0AB, 9'h100, 9'h001};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_cmp++; if (rdy2 !== 1'b1) begin n_bad++; $display("FAIL c1_ready_hi step %0d got %b want 1", i, rdy2); end
            n_cmp++; if (ov2 !== 1'b0) begin n_bad++; $display("FAIL c1_valid_lo step %0d got %b want 0", i, ov2); end
            in_valid = 1'b1;
            {carryout, sum} = vals[i];
            @(negedge clock);
            n_cmp++; if (rdy2 !== 1'b0) begin n_bad++; $display("FAIL c1_ready_lo step %0d got %b want 0", i, rdy2); end
            n_cmp++; if (ov2 !== 1'b1) begin n_bad++; $display("FAIL c1_valid_hi step %0d got %b want 1", i, ov2); end
            n_cmp++; if (tot2 !== {7'd0, vals[i]}) begin n_bad++; $display("FAIL c1_total step %0d got %h want %h", i, tot2, vals[i]); end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_gapped();
        test_backpressure();
        test_reset_mid_block();
        test_count_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
